cache_flush_ctrl: RTL and testbench
===================================

Name: cache_flush_ctrl

Overview:
- Parametrised cache invalidation sequencer; next generation of the fixed 256-set flush counter in the icache/dcache path.
- On a flush request it walks set indices 0..SETS-1, one set per cycle, and issues invalidate strobes with a per-way mask captured at start.
- Adds a start/busy/done handshake, a stall input from the tag array arbiter, queuing of a request that arrives mid-flush, and arbitrary (non-power-of-2) depth.

Parameters:
- SETS, 256, number of sets to walk; must be ≥1, any integer.
- WAYS, 4, associativity; width of the way masks; must be ≥1.
- IDX_W, $clog2(SETS) (1 if SETS==1), set index width; derived, not overridden.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- flush_req_i  in  1  flush request; sampled every cycle, single-cycle pulse or level.
- way_sel_i  in  WAYS  ways to invalidate; captured when a flush starts.
- stall_i  in  1  tag array busy; blocks the current invalidate from advancing.
- inval_valid_o  out  1  invalidate strobe for set_o / way_mask_o.
- set_o  out  IDX_W  set index being invalidated.
- way_mask_o  out  WAYS  captured way mask.
- busy_o  out  1  high while in FLUSH.
- flush_done_o  out  1  one-cycle pulse after the last set is invalidated.

Behaviour:
- Reset: state IDLE; set_q=0; way_mask_q=0; pending_q=0. All outputs are 0 at reset and in the cycle after reset.
- FSM states: IDLE, FLUSH, DONE.
- IDLE → FLUSH when flush_req_i=1. In that cycle: set_q←0, way_mask_q←way_sel_i. If way_sel_i=0, still walk all sets with a zero mask; inval_valid_o is still asserted.
- FLUSH:
  - inval_valid_o=1, set_o=set_q, way_mask_o=way_mask_q, busy_o=1.
  - If stall_i=1: hold set_q; inval_valid_o stays 1. The consumer accepts only when stall_i=0.
  - If stall_i=0 and set_q≠SETS-1: set_q←set_q+1.
  - If stall_i=0 and set_q==SETS-1: → DONE, set_q←0.
  - Latency with no stall: exactly SETS cycles of inval_valid_o, then flush_done_o in the next cycle.
- DONE: flush_done_o=1 for exactly one cycle; busy_o=0; inval_valid_o=0.
  - If pending_q=1 or flush_req_i=1: → FLUSH, recapture way_sel_i, clear pending_q.
  - Otherwise → IDLE.
- pending_q is set by flush_req_i=1 while in FLUSH. Multiple requests during one flush collapse into a single re-flush.
- Wrap/width: the index never exceeds SETS-1 and never overflows IDX_W. SETS=1 gives a one-cycle FLUSH.
- rst_i mid-flush: returns to IDLE next cycle. No flush_done_o; pending is discarded.
- Reset has priority over every other input.

Optional Feature:
- Macro: CACHE_FLUSH_RANGE_EN.
- When defined:
  - Adds inputs range_lo_i and range_hi_i (IDX_W each), captured at flush start.
  - The walk starts at range_lo_i and ends at range_hi_i.
  - If range_lo_i > range_hi_i, the range is treated as full 0..SETS-1.
  - range_hi_i ≥ SETS is clamped to SETS-1.
- When undefined: no extra ports; always walks the full 0..SETS-1.

Decomposition:
- Shared package cache_flush_pkg holds:
  - the state enum flush_state_t {IDLE, FLUSH, DONE}, 2-bit;
  - the default SETS/WAYS localparams used by icache and dcache instances.
- Sub-module flush_idx_counter: loadable up-counter with enable, end compare and last_o flag, reused by dcache writeback sweep.
- The FSM stays in the top level.

Test Plan:
- Full walk, SETS=256, WAYS=4, way_sel_i=4'b1011, one-cycle req, no stall:
  - 256 strobes, set_o 0..255, way_mask_o=1011 throughout;
  - flush_done_o at cycle 257 after req; busy_o low afterwards.
- Stall: SETS=8, stall_i high on cycles 3–5 of the walk → set_o holds 2 for 4 cycles; done arrives 3 cycles late.
- Non-power-of-2 and minimum depth:
  - SETS=5 → set_o 0..4, then done; no index 5 ever appears.
  - SETS=1 → one strobe at set_o=0, then done.
- Queued request: two extra pulses during a SETS=16 walk → done pulse immediately followed by exactly one more 16-set walk using the newly captured way_sel_i.
- Reset mid-flush: rst_i at set 100 → next cycle all outputs 0, no done pulse; a fresh req restarts at set 0.
- CACHE_FLUSH_RANGE_EN defined:
  - lo=10, hi=20 → 11 strobes, 10..20.
  - lo=30, hi=5 → full 256-set walk.

Source files
------------

// File: rtl/cache_flush_pkg.sv
// Shared types and defaults for the cache flush sequencer family.
// Optional range walk is enabled by defining CACHE_FLUSH_RANGE_EN.
package cache_flush_pkg;

    // Default geometry shared by the icache and dcache instances
    localparam int DEFAULT_SETS = 256;
    localparam int DEFAULT_WAYS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } flush_state_t;

    // Set index width; a single-set cache still needs a 1-bit index
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cache_flush_ctrl_if.sv
// Request/strobe bundle between a flush requester and cache_flush_ctrl.
// Range ports exist only when CACHE_FLUSH_RANGE_EN is defined.
interface cache_flush_ctrl_if
    import cache_flush_pkg::*;
#(
    parameter int SETS = DEFAULT_SETS,
    parameter int WAYS = DEFAULT_WAYS
);
    localparam int IDX_W = idx_width(SETS);

    logic             flush_req_i;
    logic [WAYS-1:0]  way_sel_i;
    logic             stall_i;
`ifdef CACHE_FLUSH_RANGE_EN
    logic [IDX_W-1:0] range_lo_i;
    logic [IDX_W-1:0] range_hi_i;
`endif
    logic             inval_valid_o;
    logic [IDX_W-1:0] set_o;
    logic [WAYS-1:0]  way_mask_o;
    logic             busy_o;
    logic             flush_done_o;

    modport master (
`ifdef CACHE_FLUSH_RANGE_EN
        output range_lo_i, range_hi_i,
`endif
        output flush_req_i, way_sel_i, stall_i,
        input  inval_valid_o, set_o, way_mask_o, busy_o, flush_done_o
    );

    modport slave (
`ifdef CACHE_FLUSH_RANGE_EN
        input  range_lo_i, range_hi_i,
`endif
        input  flush_req_i, way_sel_i, stall_i,
        output inval_valid_o, set_o, way_mask_o, busy_o, flush_done_o
    );

endinterface

// File: rtl/flush_idx_counter.sv
// Loadable index up-counter with enable and end-compare flag.
// Shared with the dcache writeback sweep; no optional-feature macros.
module flush_idx_counter #(
    parameter int IDX_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [IDX_W-1:0] load_val_i,
    input  logic             en_i,
    input  logic [IDX_W-1:0] end_val_i,
    output logic [IDX_W-1:0] cnt_o,
    output logic             last_o
);
    logic [IDX_W-1:0] cnt_q;
    logic [IDX_W-1:0] cnt_d;

    // Load wins over increment so a restart never skips the first index
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q + IDX_W'(1);
        end
    end

    // Index register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == end_val_i);

endmodule

// File: rtl/cache_flush_ctrl.sv
// Cache invalidation sequencer: walks set indices issuing invalidate strobes
// with a captured way mask, honouring stall and queuing one mid-flush request.
// Define CACHE_FLUSH_RANGE_EN to walk a captured lo..hi sub-range instead.
module cache_flush_ctrl
    import cache_flush_pkg::*;
#(
    parameter int SETS = DEFAULT_SETS,
    parameter int WAYS = DEFAULT_WAYS
) (
    input  logic               clk_i,
    input  logic               rst_i,
    cache_flush_ctrl_if.slave  bus
);
    localparam int IDX_W = idx_width(SETS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETS - 1);

    flush_state_t     state_q;
    logic [WAYS-1:0]  way_mask_q;
    logic [IDX_W-1:0] end_q;
    logic             pending_q;
    logic             inval_valid_q;
    logic             busy_q;
    logic             done_q;

    logic             start_now;
    logic             cnt_load;
    logic [IDX_W-1:0] cnt_load_val;
    logic             cnt_en;
    logic [IDX_W-1:0] set_cnt;
    logic             cnt_last;
    logic [IDX_W-1:0] start_lo;
    logic [IDX_W-1:0] start_hi;

`ifdef CACHE_FLUSH_RANGE_EN
    logic [IDX_W-1:0] hi_clamped;

    // Clamp hi into the cache, then fall back to a full walk if lo lies past it
    always_comb begin
        hi_clamped = (bus.range_hi_i > LAST_IDX) ? LAST_IDX : bus.range_hi_i;
        start_lo   = '0;
        start_hi   = LAST_IDX;
        if (bus.range_lo_i <= hi_clamped) begin
            start_lo = bus.range_lo_i;
            start_hi = hi_clamped;
        end
    end
`else
    assign start_lo = '0;
    assign start_hi = LAST_IDX;
`endif

    // Counter control: restart on flush start, step on accepted strobe, rewind after last
    always_comb begin
        start_now    = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_en       = 1'b0;
        case (state_q)
            IDLE:  start_now = bus.flush_req_i;
            FLUSH: begin
                if (!bus.stall_i) begin
                    if (cnt_last) cnt_load = 1'b1;
                    else          cnt_en   = 1'b1;
                end
            end
            DONE:  start_now = bus.flush_req_i | pending_q;
            default: ;
        endcase
        if (start_now) begin
            cnt_load     = 1'b1;
            cnt_load_val = start_lo;
        end
    end

    flush_idx_counter #(
        .IDX_W (IDX_W)
    ) u_idx (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .en_i       (cnt_en),
        .end_val_i  (end_q),
        .cnt_o      (set_cnt),
        .last_o     (cnt_last)
    );

    // Flush FSM with registered strobe/busy/done outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            way_mask_q    <= '0;
            end_q         <= LAST_IDX;
            pending_q     <= 1'b0;
            inval_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_now) begin
                        state_q       <= FLUSH;
                        way_mask_q    <= bus.way_sel_i;
                        end_q         <= start_hi;
                        inval_valid_q <= 1'b1;
                        busy_q        <= 1'b1;
                    end
                end
                FLUSH: begin
                    // Any number of requests during a walk collapse into one re-flush
                    if (bus.flush_req_i) pending_q <= 1'b1;
                    if (!bus.stall_i && cnt_last) begin
                        state_q       <= DONE;
                        inval_valid_q <= 1'b0;
                        busy_q        <= 1'b0;
                        done_q        <= 1'b1;
                    end
                end
                DONE: begin
                    if (start_now) begin
                        state_q       <= FLUSH;
                        way_mask_q    <= bus.way_sel_i;
                        end_q         <= start_hi;
                        pending_q     <= 1'b0;
                        inval_valid_q <= 1'b1;
                        busy_q        <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    inval_valid_q <= 1'b0;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.inval_valid_o = inval_valid_q;
    assign bus.set_o         = set_cnt;
    assign bus.way_mask_o    = way_mask_q;
    assign bus.busy_o        = busy_q;
    assign bus.flush_done_o  = done_q;

endmodule

// File: tb/tb_cache_flush_ctrl.sv
// Self-checking bench for cache_flush_ctrl across several depths.
// Range cases are added when CACHE_FLUSH_RANGE_EN is defined.
module tb_cache_flush_ctrl;

    localparam int NI = 5;
    localparam int SETS_TAB [NI] = '{256, 8, 5, 1, 16};

    typedef struct {
        logic        is_done;
        int          set;
        logic [3:0]  mask;
    } sb_t;

    typedef struct {
        int          inst;
        logic [3:0]  way;
        int          lo;
        int          hi;
        int          stall_start;
        int          stall_len;
        int          exp_first;
        int          exp_last;
        int          exp_done;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst     [NI];
    logic        req     [NI];
    logic [3:0]  way     [NI];
    logic        stall   [NI];
    int          lo      [NI];
    int          hi      [NI];
    logic        o_valid [NI];
    logic [31:0] o_set   [NI];
    logic [3:0]  o_mask  [NI];
    logic        o_busy  [NI];
    logic        o_done  [NI];

    int  checks   = 0;
    int  failures = 0;
    int  act      = 0;
    bit  mon_en   = 1'b0;
    sb_t sbq [$];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int S  = SETS_TAB[gi];
        localparam int IW = (S <= 1) ? 1 : $clog2(S);

        cache_flush_ctrl_if #(.SETS(S), .WAYS(4)) intf ();

        cache_flush_ctrl #(.SETS(S), .WAYS(4)) dut (
            .clk_i (clk),
            .rst_i (rst[gi]),
            .bus   (intf)
        );

        assign intf.flush_req_i = req[gi];
        assign intf.way_sel_i   = way[gi];
        assign intf.stall_i     = stall[gi];
`ifdef CACHE_FLUSH_RANGE_EN
        assign intf.range_lo_i  = lo[gi][IW-1:0];
        assign intf.range_hi_i  = hi[gi][IW-1:0];
`endif
        assign o_valid[gi] = intf.inval_valid_o;
        assign o_set[gi]   = 32'(intf.set_o);
        assign o_mask[gi]  = intf.way_mask_o;
        assign o_busy[gi]  = intf.busy_o;
        assign o_done[gi]  = intf.flush_done_o;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic report_bad(input string name, input logic [31:0] actual);
        checks++;
        failures++;
        $display("FAIL %s actual=%0d t=%0t", name, actual, $time);
    endtask

    // Scoreboard monitor: every strobe cycle must show the head entry; it pops on accept
    always @(negedge clk) begin
        if (mon_en) begin
            if (o_valid[act]) begin
                if (sbq.size() == 0 || sbq[0].is_done) begin
                    report_bad("strobe_unexpected", o_set[act]);
                end else begin
                    check("strobe_set", o_set[act], 32'(sbq[0].set));
                    check("strobe_mask", 32'(o_mask[act]), 32'(sbq[0].mask));
                    if (!stall[act]) void'(sbq.pop_front());
                end
            end
            if (o_done[act]) begin
                if (sbq.size() == 0 || !sbq[0].is_done) report_bad("done_unexpected", 32'(sbq.size()));
                else void'(sbq.pop_front());
            end
        end
    end

    task automatic push_walk(input int first, input int last, input logic [3:0] m);
        for (int s = first; s <= last; s++) sbq.push_back('{1'b0, s, m});
        sbq.push_back('{1'b1, 0, m});
    endtask

    task automatic check_quiet(input int k, input string tag);
        check({tag, "_valid"}, 32'(o_valid[k]), 0);
        check({tag, "_busy"},  32'(o_busy[k]),  0);
        check({tag, "_done"},  32'(o_done[k]),  0);
    endtask

    task automatic run_walk(input vec_t v);
        int k;
        int cyc;
        int done_cyc;
        int nvalid;
        k = v.inst;
        act = k;
        push_walk(v.exp_first, v.exp_last, v.way);
        @(posedge clk); #1;
        req[k] = 1'b1; way[k] = v.way; lo[k] = v.lo; hi[k] = v.hi;
        @(posedge clk); #1;
        req[k] = 1'b0;
        cyc = 1; done_cyc = -1; nvalid = 0;
        while (done_cyc < 0 && cyc <= v.exp_done + 20) begin
            stall[k] = (cyc >= v.stall_start && cyc < v.stall_start + v.stall_len);
            @(negedge clk);
            if (o_valid[k]) nvalid++;
            if (o_done[k]) done_cyc = cyc;
            @(posedge clk); #1;
            cyc++;
        end
        stall[k] = 1'b0;
        @(negedge clk);
        check("done_cycle", done_cyc, v.exp_done);
        check("strobe_count", nvalid, v.exp_last - v.exp_first + 1 + v.stall_len);
        check_quiet(k, "after_done");
        check("sb_drained", sbq.size(), 0);
        $display("walk inst=%0d sets=%0d way=%b lo=%0d hi=%0d stall=%0d@%0d done_cyc=%0d strobes=%0d",
                 k, SETS_TAB[k], v.way, v.lo, v.hi, v.stall_len, v.stall_start, done_cyc, nvalid);
        sbq.delete();
    endtask

    vec_t vecs [$];

    initial begin
        int cyc;
        int d1;
        int d2;
        int nd;
        int post18_busy;
        int noise;

        vecs.push_back('{0, 4'b1011, 0, 255, 0, 0, 0, 255, 257});
        vecs.push_back('{1, 4'b0110, 0, 7,   3, 3, 0, 7,   12});
        vecs.push_back('{2, 4'b1111, 0, 4,   0, 0, 0, 4,   6});
        vecs.push_back('{3, 4'b0001, 0, 0,   0, 0, 0, 0,   2});
        vecs.push_back('{4, 4'b0000, 0, 15,  0, 0, 0, 15,  17});
        vecs.push_back('{1, 4'b1000, 0, 7,   1, 1, 0, 7,   10});
`ifdef CACHE_FLUSH_RANGE_EN
        vecs.push_back('{0, 4'b0011, 10, 20, 0, 0, 10, 20, 12});
        vecs.push_back('{0, 4'b1100, 30, 5,  0, 0, 0, 255, 257});
        vecs.push_back('{2, 4'b0101, 1,  7,  0, 0, 1, 4,   5});
`endif

        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1; req[k] = 1'b0; way[k] = 4'b0; stall[k] = 1'b0;
            lo[k] = 0; hi[k] = SETS_TAB[k] - 1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check_quiet(k, "in_reset");
            check("in_reset_set", o_set[k], 0);
            check("in_reset_mask", 32'(o_mask[k]), 0);
        end
        @(posedge clk); #1;
        for (int k = 0; k < NI; k++) rst[k] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check_quiet(k, "post_reset");
            check("post_reset_set", o_set[k], 0);
        end
        mon_en = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_walk(vecs[i]);

        // Queued request: two pulses during a 16-set walk yield exactly one re-walk
        act = 4;
        push_walk(0, 15, 4'b0101);
        push_walk(0, 15, 4'b1110);
        @(posedge clk); #1;
        req[4] = 1'b1; way[4] = 4'b0101; lo[4] = 0; hi[4] = 15;
        @(posedge clk); #1;
        req[4] = 1'b0;
        cyc = 1; d1 = -1; d2 = -1; nd = 0; post18_busy = 0;
        while (cyc <= 45) begin
            if (cyc == 3 || cyc == 7) begin req[4] = 1'b1; way[4] = 4'b1110; end
            else req[4] = 1'b0;
            @(negedge clk);
            if (o_done[4]) begin
                nd++;
                if (d1 < 0) d1 = cyc; else d2 = cyc;
            end
            if (cyc == 18) post18_busy = (o_busy[4] && o_valid[4]) ? 1 : 0;
            @(posedge clk); #1;
            cyc++;
        end
        req[4] = 1'b0;
        check("queued_done1", d1, 17);
        check("queued_done2", d2, 34);
        check("queued_done_count", nd, 2);
        check("queued_back_to_back", post18_busy, 1);
        check("queued_sb_drained", sbq.size(), 0);
        $display("queued inst=4 done1=%0d done2=%0d dones=%0d", d1, d2, nd);
        sbq.delete();

        // Reset mid-flush at set 100: outputs clear next cycle, no done pulse
        act = 0;
        push_walk(0, 255, 4'b0101);
        @(posedge clk); #1;
        req[0] = 1'b1; way[0] = 4'b0101; lo[0] = 0; hi[0] = 255;
        @(posedge clk); #1;
        req[0] = 1'b0;
        cyc = 1;
        while (cyc < 101) begin @(posedge clk); #1; cyc++; end
        rst[0] = 1'b1;
        @(negedge clk);
        check("pre_rst_set", o_set[0], 100);
        @(posedge clk); #1;
        rst[0] = 1'b0;
        sbq.delete();
        @(negedge clk);
        check_quiet(0, "mid_rst");
        check("mid_rst_set", o_set[0], 0);
        check("mid_rst_mask", 32'(o_mask[0]), 0);
        noise = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_done[0] || o_valid[0]) noise++;
        end
        check("mid_rst_quiet", noise, 0);
        $display("midreset inst=0 set_at_rst=100 activity_after=%0d", noise);
        run_walk('{0, 4'b1001, 0, 255, 0, 0, 0, 255, 257});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
